frame_ram_scheduler: RTL

- Sequences the single-port 320x240x8 frame RAM between two users: the VGA display read path and an external pixel writer (image loader / zoom engine).
- Generates display read addresses with nearest-neighbour centre zoom (1x/2x/4x) for a 320x240 window centred in the 640x480 raster.
- Sits between the VGA timing module (next_x/next_y), the frame RAM, and the VGA color input.

---
 rtl/frame_ram_scheduler_if.sv | 40 ++++
 rtl/frame_ram_scheduler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/frame_ram_scheduler_if.sv
// Bundle of every non-clock signal that passes between the frame RAM scheduler
// and the blocks around it: the VGA timing module, the pixel writer, the frame RAM
// and the VGA color input.
//   slave  : the scheduler's view of the bundle.
//   master : the environment's view (timing, writer, RAM, display).
// Signals:
//   next_x/next_y          raster position to fetch (from VGA timing)
//   zoom_sel/zoom_apply    zoom request and its one-cycle latch pulse
//   wr_req/wr_addr/wr_data writer request, held until wr_ack
//   wr_ack/wr_err          write done / write dropped (address out of range)
//   ram_address/ram_data/ram_wren/ram_q   single-port frame RAM
//   color_out              pixel to the VGA color input
//   zoom_active            zoom currently in effect
interface frame_ram_scheduler_if;
   logic [9:0]  next_x;
   logic [9:0]  next_y;
   logic [1:0]  zoom_sel;
   logic        zoom_apply;
   logic        wr_req;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic        wr_err;
   logic [16:0] ram_address;
   logic [7:0]  ram_data;
   logic        ram_wren;
   logic [7:0]  ram_q;
   logic [7:0]  color_out;
   logic [1:0]  zoom_active;

   modport slave (
      input  next_x, next_y, zoom_sel, zoom_apply, wr_req, wr_addr, wr_data, ram_q,
      output wr_ack, wr_err, ram_address, ram_data, ram_wren, color_out, zoom_active
   );

   modport master (
      output next_x, next_y, zoom_sel, zoom_apply, wr_req, wr_addr, wr_data, ram_q,
      input  wr_ack, wr_err, ram_address, ram_data, ram_wren, color_out, zoom_active
   );
endinterface

// File: rtl/frame_ram_scheduler.sv
// Frame RAM scheduler: shares the single-port 320x240x8 frame RAM between the VGA
// display read path and an external pixel writer.  The display always wins; the
// writer only gets a cycle when the raster is outside the centred image window.
// Display addresses apply nearest-neighbour centre zoom (1x/2x/4x).
// Ports:
//   clock  system clock (shared with VGA timing and the RAM)
//   reset  asynchronous, active-high
//   bus    frame_ram_scheduler_if.slave -- raster position, zoom control, writer
//          handshake, RAM port and color output
module frame_ram_scheduler #(
   parameter int          H_START  = 160,
   parameter int          V_START  = 120,
   parameter int          IMG_W    = 320,
   parameter int          IMG_H    = 240,
   parameter logic [7:0]  BG_COLOR = 8'h00
) (
   input  logic                   clock,
   input  logic                   reset,
   frame_ram_scheduler_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

   localparam logic [16:0] PIX = 17'(IMG_W * IMG_H);

   state_e      state_q, state_d;
   logic [16:0] ram_address_q, ram_address_d;
   logic [7:0]  ram_data_q, ram_data_d;
   logic        ram_wren_q, ram_wren_d;
   logic        wr_ack_q, wr_ack_d;
   logic        wr_err_q, wr_err_d;
   logic [7:0]  color_q;
   logic [1:0]  zoom_act_q, zoom_pend_q;
   logic [1:0]  vld_pipe;   // [0] aligned with ram_address, [1] aligned with ram_q

   logic        in_win;
   logic [9:0]  dx, dy;
   logic [8:0]  ox, sx;
   logic [7:0]  oy, sy;
   logic [16:0] disp_addr;

   assign in_win = (bus.next_x >= 10'(H_START)) && (bus.next_x < 10'(H_START + IMG_W)) &&
                   (bus.next_y >= 10'(V_START)) && (bus.next_y < 10'(V_START + IMG_H));

   // Only meaningful inside the window; outside it the address is not used.
   assign dx = bus.next_x - 10'(H_START);
   assign dy = bus.next_y - 10'(V_START);

   // Offsets centre the zoomed sub-image inside the source frame.
   always_comb begin
      ox = '0;
      oy = '0;
      case (zoom_act_q)
         2'b01: begin
            ox = 9'((IMG_W - (IMG_W >> 1)) / 2);
            oy = 8'((IMG_H - (IMG_H >> 1)) / 2);
         end
         2'b10: begin
            ox = 9'((IMG_W - (IMG_W >> 2)) / 2);
            oy = 8'((IMG_H - (IMG_H >> 2)) / 2);
         end
         default: ;
      endcase
   end

   assign sx = ox + 9'(dx >> zoom_act_q);
   assign sy = oy + 8'(dy >> zoom_act_q);
   // sy*320 + sx without a multiplier
   assign disp_addr = 17'({sy, 8'b0}) + 17'({sy, 6'b0}) + 17'(sx);

   // A write is granted only when the display is idle and the previous cycle was
   // not itself a write, which guarantees a gap between consecutive acks.
   always_comb begin
      state_d       = IDLE;
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      ram_wren_d    = 1'b0;
      wr_ack_d      = 1'b0;
      wr_err_d      = 1'b0;
      if (in_win) begin
         state_d       = READ;
         ram_address_d = disp_addr;
      end else if (bus.wr_req && (state_q != WRITE)) begin
         state_d       = WRITE;
         ram_address_d = bus.wr_addr;
         ram_data_d    = bus.wr_data;
         ram_wren_d    = (bus.wr_addr < PIX);
         wr_ack_d      = 1'b1;
         wr_err_d      = (bus.wr_addr >= PIX);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         ram_wren_q    <= 1'b0;
         wr_ack_q      <= 1'b0;
         wr_err_q      <= 1'b0;
         vld_pipe      <= '0;
         color_q       <= BG_COLOR;
         zoom_act_q    <= 2'b00;
         zoom_pend_q   <= 2'b00;
      end else begin
         state_q       <= state_d;
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         ram_wren_q    <= ram_wren_d;
         wr_ack_q      <= wr_ack_d;
         wr_err_q      <= wr_err_d;
         vld_pipe      <= {vld_pipe[0], (state_d == READ)};
         color_q       <= vld_pipe[1] ? bus.ram_q : BG_COLOR;
         // Zoom only changes at the frame origin; the pending value read here is
         // the old one, so a simultaneous apply lands at the next frame.
         if ((bus.next_x == 10'd0) && (bus.next_y == 10'd0))
            zoom_act_q <= zoom_pend_q;
         if (bus.zoom_apply)
            zoom_pend_q <= (bus.zoom_sel == 2'b11) ? 2'b00 : bus.zoom_sel;
      end
   end

   assign bus.ram_address = ram_address_q;
   assign bus.ram_data    = ram_data_q;
   assign bus.ram_wren    = ram_wren_q;
   assign bus.wr_ack      = wr_ack_q;
   assign bus.wr_err      = wr_err_q;
   assign bus.color_out   = color_q;
   assign bus.zoom_active = zoom_act_q;
endmodule
